// File: rtl/bank_config_writer.sv
// rtl/bank_config_writer.sv - BL/WL configuration bank programmer
// Assembles one BL row from a word stream, then fires the row's WL with setup/pulse/hold timing.
module bank_config_writer #(
   parameter int BL_WIDTH  = 315,
   parameter int WL_WIDTH  = 4,
   parameter int DW        = 16,
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 2,
   localparam int NW = (BL_WIDTH + DW - 1) / DW,
   localparam int RW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [DW-1:0]       s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [BL_WIDTH-1:0] bl,
   output logic [WL_WIDTH-1:0] wl,
   output logic                busy,
   output logic                done,
   output logic [RW-1:0]       row
);

   localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
   localparam int IW  = $clog2(NW * DW + 1);
   localparam int CW  = 16;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_PULSE, S_HOLD} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BL_WIDTH-1:0] r_bl;
   logic [BL_WIDTH-1:0] w_bl_nxt;
   logic [WL_WIDTH-1:0] r_wl;
   logic [RW-1:0]       r_row;
   logic [WCW-1:0]      r_word;
   logic [CW-1:0]       r_cnt;
   logic                r_ready;
   logic                r_busy;
   logic                r_done;
   logic                w_accept;
   logic                w_last_word;
   logic                w_cnt_zero;
   logic                w_last_row;
   logic                w_done_nxt;
   logic                w_load_cnt;
   logic [CW-1:0]       w_cnt_init;
   logic [IW-1:0]       w_base;
   logic [IW-1:0]       w_idx;

   assign w_accept    = (r_state == S_LOAD) && s_valid;
   assign w_last_word = (r_word == WCW'(NW - 1));
   assign w_cnt_zero  = (r_cnt == '0);
   assign w_last_row  = (r_row == RW'(WL_WIDTH - 1));
   assign w_base      = IW'(r_word) * IW'(DW);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_load_cnt  = 1'b0;
      w_cnt_init  = '0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (w_accept && w_last_word) begin
               w_state_nxt = S_SETUP;
               w_load_cnt  = 1'b1;
               w_cnt_init  = CW'(SETUP_CYC - 1);
            end
         end
         S_SETUP: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_PULSE;
               w_load_cnt  = 1'b1;
               w_cnt_init  = CW'(PULSE_CYC - 1);
            end
         end
         S_PULSE: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_HOLD;
               w_load_cnt  = 1'b1;
               w_cnt_init  = CW'(HOLD_CYC - 1);
            end
         end
         S_HOLD: begin
            if (w_cnt_zero) begin
               if (w_last_row) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_LOAD;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bits of the final word that fall past BL_WIDTH are dropped here.
   always_comb begin
      w_bl_nxt = r_bl;
      w_idx    = '0;
      for (int i = 0; i < DW; i++) begin
         w_idx = w_base + IW'(i);
         if (w_idx < IW'(BL_WIDTH)) w_bl_nxt[w_idx] = s_data[i];
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bl    <= '0;
         r_wl    <= '0;
         r_row   <= '0;
         r_word  <= '0;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_ready <= (w_state_nxt == S_LOAD);
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
         r_wl    <= (w_state_nxt == S_PULSE) ? (WL_WIDTH'(1) << r_row) : '0;
         if (w_load_cnt) begin
            r_cnt <= w_cnt_init;
         end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_row  <= '0;
                  r_bl   <= '0;
                  r_word <= '0;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_bl   <= w_bl_nxt;
                  r_word <= w_last_word ? '0 : r_word + WCW'(1);
               end
            end
            S_HOLD: begin
               if (w_cnt_zero && !w_last_row) begin
                  r_row  <= r_row + RW'(1);
                  r_word <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_ready = r_ready;
   assign bl      = r_bl;
   assign wl      = r_wl;
   assign busy    = r_busy;
   assign done    = r_done;
   assign row     = r_row;

endmodule

// File: tb/tb_bank_config_writer.sv
// tb/tb_bank_config_writer.sv - scoreboard bench for bank_config_writer
// Row images are queued as words are driven and compared when the row's WL pulse appears.
module tb_bank_config_writer;

   localparam int BL      = 315;
   localparam int WL      = 4;
   localparam int DW      = 16;
   localparam int NW      = 20;
   localparam int SETUP   = 2;
   localparam int PULSE   = 4;
   localparam int HOLD    = 2;
   localparam int ROW_CYC = NW + SETUP + PULSE + HOLD;

   typedef struct {
      logic [BL-1:0] bl;
      logic [WL-1:0] wl;
      int            row;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [BL-1:0] bl;
   logic [WL-1:0] wl;
   logic          busy;
   logic          done;
   logic [1:0]    row;

   int            checks;
   int            errors;
   int            cyc;
   logic [BL-1:0] m_bl;
   int            m_row;
   int            m_word;
   int            stall_left;
   int            stalls_total;
   int            done_cnt;
   int            first_ready_cyc;
   int            last_acc_cyc;
   int            rise_cyc;
   int            fall_cyc;
   bit            hold_pending;
   logic [WL-1:0] prev_wl;
   exp_t          sb[$];

   bank_config_writer #(
      .BL_WIDTH (BL),
      .WL_WIDTH (WL),
      .DW       (DW),
      .SETUP_CYC(SETUP),
      .PULSE_CYC(PULSE),
      .HOLD_CYC (HOLD)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .s_data (s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .bl     (bl),
      .wl     (wl),
      .busy   (busy),
      .done   (done),
      .row    (row)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] word_val(input int mode, input int r, input int k);
      if (mode == 1 && r == 0) return (k == NW - 1) ? 16'hFFFF : 16'h0000;
      return {4'(r), 12'(k)};
   endfunction

   task automatic cycle_step(input int mode, input bit start_req, input bit b2b);
      exp_t                e;
      logic [DW-1:0]       d;
      logic [NW*DW-1:0]    pad;
      @(negedge clk);
      cyc++;
      if (wl != '0 && prev_wl == '0) begin
         check("sb_depth", sb.size(), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pulse_wl", wl, e.wl);
            check("pulse_bl", bl, e.bl);
            check("pulse_row", row, e.row);
         end
         check("setup_len", cyc - last_acc_cyc, SETUP + 1);
         if (mode == 1 && row == 2'd0) begin
            check("trunc_hi", bl[314:304], 11'h7FF);
            check("trunc_lo", bl[303:0], '0);
         end
         rise_cyc = cyc;
      end
      if (wl == '0 && prev_wl != '0) begin
         check("pulse_len", cyc - rise_cyc, PULSE);
         fall_cyc     = cyc;
         hold_pending = 1'b1;
      end
      if (hold_pending && (s_ready || done)) begin
         check("hold_len", cyc - fall_cyc, HOLD);
         hold_pending = 1'b0;
      end
      if (busy && !s_ready) check("bl_stable", bl, m_bl);
      if (s_ready && first_ready_cyc < 0) begin
         first_ready_cyc = cyc;
         check("sess_row", row, 0);
         check("sess_bl", bl, '0);
      end
      if (done) begin
         done_cnt++;
         check("done_busy", busy, 0);
         check("done_time", cyc - first_ready_cyc, 4 * ROW_CYC + stalls_total);
      end
      prev_wl = wl;

      start   = start_req || (mode == 3 && done_cnt == 0) || (b2b && done);
      s_valid = (mode == 3);
      s_data  = 16'($urandom);
      if (s_ready) begin
         if (stall_left > 0) begin
            s_valid = 1'b0;
            stall_left--;
            stalls_total++;
         end else begin
            d       = word_val(mode, m_row, m_word);
            s_valid = 1'b1;
            s_data  = d;
            pad     = {{(NW*DW-BL){1'b0}}, m_bl};
            pad[m_word*DW +: DW] = d;
            m_bl    = pad[BL-1:0];
            last_acc_cyc = cyc;
            if (mode == 2 && m_row == 1 && m_word == 7) stall_left = 5;
            m_word++;
            if (m_word == NW) begin
               e.bl  = m_bl;
               e.wl  = 4'b0001 << m_row;
               e.row = m_row;
               sb.push_back(e);
               m_word = 0;
               m_row++;
            end
         end
      end
   endtask

   task automatic run_session(input int mode, input bit b2b, input bit started, input bit abort);
      bit fin = 1'b0;
      bit hit = 1'b0;
      m_bl            = '0;
      m_row           = 0;
      m_word          = 0;
      stall_left      = 0;
      stalls_total    = 0;
      done_cnt        = 0;
      first_ready_cyc = -1;
      hold_pending    = 1'b0;
      sb.delete();
      for (int t = 0; t < 400 && !fin; t++) begin
         cycle_step(mode, (t == 0) && !started, b2b);
         if (done_cnt > 0) fin = 1'b1;
         if (abort && wl != '0 && row == 2'd2) begin
            hit = 1'b1;
            fin = 1'b1;
         end
      end
      if (abort) begin
         check("abort_reached", hit, 1);
         #2 reset = 1'b0;
         #1;
         check("abort_wl", wl, '0);
         check("abort_bl", bl, '0);
         check("abort_busy", busy, 0);
         check("abort_ready", s_ready, 0);
         @(negedge clk);
         reset   = 1'b1;
         start   = 1'b0;
         s_valid = 1'b1;
         prev_wl = '0;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_ready", s_ready, 0);
            check("post_reset_busy", busy, 0);
         end
         s_valid = 1'b0;
      end else if (!b2b) begin
         for (int i = 0; i < 3; i++) cycle_step(0, 1'b0, 1'b0);
         check("done_count", done_cnt, 1);
      end else begin
         check("done_count_b2b", done_cnt, 1);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      cyc          = 0;
      last_acc_cyc = 0;
      rise_cyc     = 0;
      fall_cyc     = 0;
      prev_wl      = '0;
      reset        = 1'b0;
      start        = 1'b0;
      s_valid      = 1'b0;
      s_data       = '0;
      repeat (2) @(negedge clk);
      check("rst_bl", bl, '0);
      check("rst_wl", wl, '0);
      check("rst_row", row, 0);
      check("rst_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_ready", s_ready, 0);

      run_session(0, 1'b0, 1'b0, 1'b0);
      run_session(1, 1'b0, 1'b0, 1'b0);
      run_session(2, 1'b0, 1'b0, 1'b0);
      run_session(3, 1'b0, 1'b0, 1'b0);
      run_session(0, 1'b1, 1'b0, 1'b0);
      run_session(0, 1'b0, 1'b1, 1'b0);
      run_session(0, 1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
